bsg_clk_downsample_ctrl: RTL and testbench
==========================================

BSG_CLK_DOWNSAMPLE_CTRL -- requirements
Module: bsg_clk_downsample_ctrl

Interface
REQ-001 SHALL have parameter width_p, default 16: width of the divider value bus.
REQ-002 SHALL have parameter init_val_p, default 0: divider value loaded at reset.
REQ-003 SHALL have parameter hold_cycles_p, default 4, minimum 1: number of cycles ds_reset_o is held high per reconfiguration.
REQ-004 SHALL have parameter lock_edges_p, default 2, minimum 1: number of ds_clk_i toggles required to declare lock.
REQ-005 SHALL have parameter slack_p, default 8: watchdog margin added to the divider value.
REQ-006 SHALL have port clk_i  input  1  single clock; all logic is on its posedge.
REQ-007 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port v_i  input  1  new divider request valid.
REQ-009 SHALL have port val_i  input  width_p  requested divider value.
REQ-010 SHALL have port ready_o  output  1  request is accepted on the cycle where v_i & ready_o.
REQ-011 SHALL have port ds_reset_o  output  1  active-high reset driven to the downsampler.
REQ-012 SHALL have port ds_val_o  output  width_p  divider value driven to the downsampler.
REQ-013 SHALL have port ds_clk_i  input  1  downsampled clock returned from the downsampler, synchronous to clk_i.
REQ-014 SHALL have port locked_o  output  1  downsampled clock is running at the current ds_val_o.
REQ-015 SHALL have port err_o  output  1  watchdog expired before lock, or lost toggling while locked.

Function
REQ-016 SHALL implement an FSM with states HOLD, WAIT_LOCK, LOCKED and ERROR.
REQ-017 HOLD: ds_reset_o=1; a hold counter counts hold_cycles_p cycles, then the FSM goes to WAIT_LOCK.
REQ-018 WAIT_LOCK: ds_reset_o=0; the FSM counts toggles and goes to LOCKED on the lock_edges_p-th toggle.
REQ-019 Toggle detection: toggle = ds_clk_i ^ ds_clk_r, where ds_clk_r is a register of ds_clk_i.
REQ-020 ds_clk_r SHALL be forced to 0 while in HOLD.
REQ-021 Watchdog: in WAIT_LOCK and LOCKED, a counter of width_p+1 bits counts cycles since the last toggle and clears on each toggle.
REQ-022 Watchdog limit: reaching ds_val_o + slack_p (computed in width_p+1 bits, no wrap) SHALL move the FSM to ERROR.
REQ-023 The watchdog counter and toggle counter SHALL clear on entry to WAIT_LOCK.
REQ-024 LOCKED: locked_o=1 and ready_o=1.
REQ-025 ERROR: err_o=1 and ready_o=1; ds_reset_o=0; ERROR is sticky until a request is accepted.
REQ-026 ready_o SHALL be 0 in HOLD and WAIT_LOCK; v_i in those states SHALL be ignored and not queued.
REQ-027 Accept at edge k: ds_val_o <= val_i; the FSM enters HOLD at k+1; locked_o, err_o and ready_o are 0 from k+1.
REQ-028 ds_val_o SHALL change only on accept or reset, and stays stable through HOLD, WAIT_LOCK and LOCKED.
REQ-029 Simultaneous accept and watchdog expiry in LOCKED: the accept wins and the FSM goes to HOLD.
REQ-030 Simultaneous accept and toggle: the accept wins; the toggle is discarded.
REQ-031 A lock_edges_p-th toggle in the same cycle as watchdog expiry SHALL count as lock, not error.
REQ-032 All outputs SHALL be registered or decoded directly from FSM state; there is no combinational path from v_i or val_i to any output.

Reset
REQ-033 Assertion of reset_n_i=0 SHALL immediately and asynchronously set the FSM to HOLD with the hold counter at 0.
REQ-034 Values during reset: ds_reset_o=1, ds_val_o=init_val_p, ready_o=0, locked_o=0, err_o=0, ds_clk_r=0.
REQ-035 Reset mid-operation SHALL discard any in-progress reconfiguration and restart the full HOLD sequence with init_val_p.
REQ-036 After deassertion, the first HOLD count SHALL begin on the first posedge clk_i.

Verification
REQ-037 Reset release, init_val_p=0, hold 4, lock 2, with a real downsampler -> ds_reset_o high 4 cycles, locked_o=1 after 2 ds_clk_i toggles, ready_o=1, err_o=0.
REQ-038 In LOCKED, v_i=1, val_i=3 for one cycle -> ds_val_o=3 next cycle, ready_o=0, ds_reset_o=1 for 4 cycles, then relock, with ds_clk_i period 8 clk_i cycles.
REQ-039 In LOCKED, ds_clk_i held at 0 (model stuck) with ds_val_o=3, slack 8 -> err_o=1 and locked_o=0 within 11 cycles of the last toggle; err_o stays 1 until the next accepted request.
REQ-040 v_i=1 pulsed during HOLD and during WAIT_LOCK -> ignored; ds_val_o unchanged; sequence completes normally.
REQ-041 reset_n_i pulsed low mid-WAIT_LOCK while ds_val_o=5 -> asynchronously ds_reset_o=1, ds_val_o=init_val_p, locked_o=0; full sequence repeats.
REQ-042 val_i=16'hFFFF accepted -> watchdog limit 16'hFFFF+8 computed without wrap; lock is reached with no false err_o.

Source files
------------

// File: rtl/bsg_clk_downsample_ctrl.sv
// Sequences reset and divider updates for a clock downsampler, then watches the
// returned clock for lock and for loss of toggling.
module bsg_clk_downsample_ctrl #(
  parameter int unsigned         width_p       = 16,
  parameter logic [width_p-1:0]  init_val_p    = '0,
  parameter int unsigned         hold_cycles_p = 4,
  parameter int unsigned         lock_edges_p  = 2,
  parameter int unsigned         slack_p       = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] val_i,
  output logic               ready_o,
  output logic               ds_reset_o,
  output logic [width_p-1:0] ds_val_o,
  input  logic               ds_clk_i,
  output logic               locked_o,
  output logic               err_o
);

  localparam int unsigned HoldW = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
  localparam int unsigned LockW = (lock_edges_p > 1) ? $clog2(lock_edges_p) : 1;
  localparam int unsigned WdW   = width_p + 1;

  localparam logic [HoldW-1:0] HoldLast = HoldW'(hold_cycles_p - 1);
  localparam logic [LockW-1:0] LockLast = LockW'(lock_edges_p - 1);

  typedef enum logic [1:0] {StHold, StWaitLock, StLocked, StError} state_e;

  state_e             r_state, w_state_nxt;
  logic [HoldW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [LockW-1:0]   r_tog_cnt, w_tog_cnt_nxt;
  logic [WdW-1:0]     r_wd_cnt, w_wd_cnt_nxt;
  logic               r_ds_clk;
  logic [width_p-1:0] r_ds_val;

  logic               w_toggle;
  logic               w_accept;
  logic [WdW-1:0]     w_wd_limit;
  logic [WdW-1:0]     w_wd_inc;
  logic               w_expire;

  assign ready_o    = (r_state == StLocked) || (r_state == StError);
  assign ds_reset_o = (r_state == StHold);
  assign locked_o   = (r_state == StLocked);
  assign err_o      = (r_state == StError);
  assign ds_val_o   = r_ds_val;

  assign w_toggle = ds_clk_i ^ r_ds_clk;
  assign w_accept = v_i & ready_o;

  // Limit carries one extra bit so a maximal divider plus slack cannot wrap.
  assign w_wd_limit = {1'b0, r_ds_val} + WdW'(slack_p);
  assign w_wd_inc   = r_wd_cnt + WdW'(1);
  assign w_expire   = (w_wd_inc >= w_wd_limit);

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_tog_cnt_nxt  = r_tog_cnt;
    w_wd_cnt_nxt   = r_wd_cnt;
    if (w_accept) begin
      w_state_nxt    = StHold;
      w_hold_cnt_nxt = '0;
    end else begin
      case (r_state)
        StHold: begin
          if (r_hold_cnt == HoldLast) begin
            w_state_nxt   = StWaitLock;
            w_tog_cnt_nxt = '0;
            w_wd_cnt_nxt  = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HoldW'(1);
          end
        end
        StWaitLock: begin
          // A toggle always clears the watchdog, so the final edge wins over expiry.
          if (w_toggle) begin
            w_wd_cnt_nxt = '0;
            if (r_tog_cnt == LockLast) begin
              w_state_nxt = StLocked;
            end else begin
              w_tog_cnt_nxt = r_tog_cnt + LockW'(1);
            end
          end else if (w_expire) begin
            w_state_nxt = StError;
          end else begin
            w_wd_cnt_nxt = w_wd_inc;
          end
        end
        StLocked: begin
          if (w_toggle) begin
            w_wd_cnt_nxt = '0;
          end else if (w_expire) begin
            w_state_nxt = StError;
          end else begin
            w_wd_cnt_nxt = w_wd_inc;
          end
        end
        StError: begin
        end
        default: begin
          w_state_nxt    = StHold;
          w_hold_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= StHold;
      r_hold_cnt <= '0;
      r_tog_cnt  <= '0;
      r_wd_cnt   <= '0;
      r_ds_clk   <= 1'b0;
      r_ds_val   <= init_val_p;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_tog_cnt  <= w_tog_cnt_nxt;
      r_wd_cnt   <= w_wd_cnt_nxt;
      r_ds_clk   <= (r_state == StHold) ? 1'b0 : ds_clk_i;
      if (w_accept) begin
        r_ds_val <= val_i;
      end
    end
  end

endmodule

// File: tb/tb_bsg_clk_downsample_ctrl.sv
// Bench for bsg_clk_downsample_ctrl: a cycle model of the lock/watchdog rules is
// compared every cycle, and directed scenarios add literal checks.
module tb_bsg_clk_downsample_ctrl;

  localparam int Width = 16;
  localparam int Hold  = 4;
  localparam int Lock  = 2;
  localparam int Slack = 8;
  localparam int Init  = 0;

  localparam int MHold   = 0;
  localparam int MWait   = 1;
  localparam int MLocked = 2;
  localparam int MErr    = 3;

  logic             clk_i     = 1'b0;
  logic             reset_n_i = 1'b1;
  logic             v_i       = 1'b0;
  logic [Width-1:0] val_i     = '0;
  logic             ready_o;
  logic             ds_reset_o;
  logic [Width-1:0] ds_val_o;
  logic             ds_clk_i;
  logic             locked_o;
  logic             err_o;

  int n_checks = 0;
  int n_errors = 0;

  bsg_clk_downsample_ctrl #(
    .width_p      (Width),
    .init_val_p   (Width'(Init)),
    .hold_cycles_p(Hold),
    .lock_edges_p (Lock),
    .slack_p      (Slack)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .val_i     (val_i),
    .ready_o   (ready_o),
    .ds_reset_o(ds_reset_o),
    .ds_val_o  (ds_val_o),
    .ds_clk_i  (ds_clk_i),
    .locked_o  (locked_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Downsampler stand-in. mode 0: real divider (toggle every val+1 cycles),
  // mode 1: stuck low, mode 2: toggle every 10 cycles regardless of val.
  int   ds_mode = 0;
  int   ds_cnt  = 0;
  logic ds_clk_q = 1'b0;
  assign ds_clk_i = ds_clk_q;

  always @(posedge clk_i) begin
    if (ds_reset_o === 1'b1) begin
      ds_cnt   <= 0;
      ds_clk_q <= 1'b0;
    end else if (ds_mode == 1) begin
      ds_clk_q <= 1'b0;
    end else if (ds_mode == 2) begin
      if (ds_cnt >= 9) begin
        ds_cnt   <= 0;
        ds_clk_q <= ~ds_clk_q;
      end else begin
        ds_cnt <= ds_cnt + 1;
      end
    end else begin
      if (ds_cnt >= int'(ds_val_o)) begin
        ds_cnt   <= 0;
        ds_clk_q <= ~ds_clk_q;
      end else begin
        ds_cnt <= ds_cnt + 1;
      end
    end
  end

  // Reference model: phase plus plain integer countdowns and a silence counter.
  int m_mode       = MHold;
  int m_hold_left  = Hold;
  int m_edges_left = Lock;
  int m_silent     = 0;
  int m_val        = Init;
  bit m_prev       = 1'b0;
  bit m_acc;
  bit m_tog;

  initial begin
    forever begin
      @(posedge clk_i or negedge reset_n_i);
      if (!reset_n_i) begin
        m_mode      = MHold;
        m_hold_left = Hold;
        m_val       = Init;
        m_prev      = 1'b0;
      end else begin
        m_acc  = v_i && (m_mode == MLocked || m_mode == MErr);
        m_tog  = (ds_clk_i != m_prev);
        m_prev = (m_mode == MHold) ? 1'b0 : ds_clk_i;
        if (m_acc) begin
          m_val       = int'(val_i);
          m_mode      = MHold;
          m_hold_left = Hold;
        end else if (m_mode == MHold) begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            m_mode       = MWait;
            m_edges_left = Lock;
            m_silent     = 0;
          end
        end else if (m_mode == MWait || m_mode == MLocked) begin
          if (m_tog) begin
            m_silent = 0;
            if (m_mode == MWait) begin
              m_edges_left--;
              if (m_edges_left == 0) m_mode = MLocked;
            end
          end else begin
            m_silent++;
            if (m_silent >= m_val + Slack) m_mode = MErr;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    check("ds_reset_o", 32'(ds_reset_o), 32'(m_mode == MHold));
    check("ready_o",    32'(ready_o),    32'(m_mode == MLocked || m_mode == MErr));
    check("locked_o",   32'(locked_o),   32'(m_mode == MLocked));
    check("err_o",      32'(err_o),      32'(m_mode == MErr));
    check("ds_val_o",   32'(ds_val_o),   32'(m_val));
  end

  task automatic send(input logic [Width-1:0] v);
    v_i   = 1'b1;
    val_i = v;
    @(negedge clk_i);
    v_i   = 1'b0;
  endtask

  task automatic wait_locked(input int budget, input string name);
    int n = 0;
    while (locked_o !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(locked_o), 32'd1);
  endtask

  task automatic wait_hold_done(input int budget, input string name);
    int n = 0;
    while (ds_reset_o !== 1'b0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(ds_reset_o), 32'd0);
  endtask

  task automatic count_hold(output int n);
    n = 0;
    while (ds_reset_o === 1'b1 && n < 20) begin
      n++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ds_reset", 32'(ds_reset_o), 32'd1);
    check("rst_ds_val",   32'(ds_val_o),   32'(Init));
    check("rst_ready",    32'(ready_o),    32'd0);

    // Bring-up with the real divider at val 0.
    reset_n_i = 1'b1;
    count_hold(n);
    check("hold_len_boot", 32'(n), 32'd4);
    wait_locked(50, "lock_boot");
    check("boot_ready", 32'(ready_o), 32'd1);
    check("boot_err",   32'(err_o),   32'd0);

    // Reconfigure to 3 from LOCKED.
    send(16'd3);
    check("acc3_ds_val", 32'(ds_val_o),   32'd3);
    check("acc3_ready",  32'(ready_o),    32'd0);
    check("acc3_reset",  32'(ds_reset_o), 32'd1);
    count_hold(n);
    check("hold_len_acc3", 32'(n), 32'd4);
    wait_locked(100, "lock_acc3");

    // Requests during HOLD and WAIT_LOCK are dropped.
    send(16'd5);
    send(16'd9);
    wait_hold_done(20, "hold_done_5");
    send(16'd7);
    check("ignored_ds_val", 32'(ds_val_o), 32'd5);
    wait_locked(100, "lock_5");
    check("lock5_ds_val", 32'(ds_val_o), 32'd5);

    // Asynchronous reset in WAIT_LOCK.
    send(16'd5);
    wait_hold_done(20, "hold_done_5b");
    repeat (2) @(negedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    check("arst_ds_reset", 32'(ds_reset_o), 32'd1);
    check("arst_ds_val",   32'(ds_val_o),   32'(Init));
    check("arst_locked",   32'(locked_o),   32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    count_hold(n);
    check("hold_len_arst", 32'(n), 32'd4);
    wait_locked(50, "lock_arst");

    // Stuck downsampled clock at val 3 trips the watchdog.
    send(16'd3);
    wait_locked(100, "lock_pre_stuck");
    ds_mode = 1;
    n = 0;
    while (err_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("stuck_err",     32'(err_o),    32'd1);
    check("stuck_latency", 32'(n <= 14),  32'd1);
    check("stuck_unlock",  32'(locked_o), 32'd0);
    repeat (20) @(negedge clk_i);
    check("err_sticky", 32'(err_o), 32'd1);
    ds_mode = 0;
    send(16'd3);
    check("err_clear", 32'(err_o), 32'd0);
    wait_locked(100, "lock_after_err");

    // Maximal divider: the watchdog limit must not wrap.
    send(16'hFFFF);
    ds_mode = 2;
    wait_locked(200, "lock_ffff");
    check("ffff_err",    32'(err_o),    32'd0);
    check("ffff_ds_val", 32'(ds_val_o), 32'hFFFF);
    repeat (30) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
